line_buffer_ctrl: RTL and testbench
===================================

Name: line_buffer_ctrl

Overview:
Control stage directly upstream of the Nin-channel line buffer array.
- Walks the zero-padded input feature map (H_P = h+2*pad_h rows by W_P = w+2*pad_w columns) in raster order.
- Consumes one pixel from the previous layer at each interior position. Injects a zero push at each padding position.
- Drives the line buffer's push and zero controls.
- Flags the cycles in which the line buffer's Kh x Kw sliding window is complete and valid for the downstream conv/PE stage.
- Data does not pass through this block: prev_layer_data goes straight to the line buffer array.

Parameters:
Kh, 3, kernel height
Kw, 3, kernel width
h, 5, unpadded input rows
w, 5, unpadded input columns
pad_h, 1, rows of zero padding top and bottom
pad_w, 1, columns of zero padding left and right

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset (rst==0 resets on the rising clk edge)
prev_valid  in  1  previous layer presents a valid pixel (all Nin channels)
prev_ready  out  1  this stage consumes the presented pixel this cycle
out_ready  in  1  downstream can accept a new window next cycle; 0 stalls all pushes
line_buffer_valid  out  1  push strobe to the line buffer array
line_buffer_zero  out  1  push a zero instead of prev_layer_data
window_valid  out  1  line buffer window is valid this cycle
window_row  out  clog2(h+2*pad_h-Kh+1)  output row index of the valid window
window_col  out  clog2(w+2*pad_w-Kw+1)  output column index of the valid window
frame_done  out  1  one-cycle pulse, registered, after the last push of a frame

Behaviour:
- State: row counter r in [0,H_P-1] and column counter c in [0,W_P-1], both registered; both reset to 0.
- is_pad = (r<pad_h) | (r>=pad_h+h) | (c<pad_w) | (c>=pad_w+w). Combinational from r and c.
- push = rst & out_ready & (is_pad | prev_valid).
- Combinational outputs:
  - line_buffer_valid = push.
  - line_buffer_zero = push & is_pad.
  - prev_ready = rst & out_ready & ~is_pad.
  - prev_ready never depends on prev_valid, so there is no combinational loop.
- Pad pushes never consume input. A pixel presented during a pad position is held: prev_ready=0.
- On push, c advances. When c==W_P-1, c wraps to 0 and r increments. When r==H_P-1 and c==W_P-1, both wrap to 0. No push means r and c hold.
- window_valid, window_row and window_col are registered and update every cycle:
  - window_valid <= push & (r>=Kh-1) & (c>=Kw-1). Latency is 1 cycle after the completing push, which matches the line buffer's single-cycle write.
  - window_row <= r-(Kh-1) and window_col <= c-(Kw-1) when the window_valid condition holds; otherwise they hold their value.
- frame_done <= push & (r==H_P-1) & (c==W_P-1).
- Stride is 1. Per frame: H_P*W_P pushes, h*w consumes, (H_P-Kh+1)*(W_P-Kw+1) windows.
- Reset values:
  - window_valid=0, frame_done=0, window_row=0, window_col=0, r=0, c=0.
  - While rst==0, all combinational outputs are 0.
- Reset mid-frame: counters return to (0,0) and the partial frame is abandoned. The line buffer contents are stale, but no window is flagged until Kh-1 rows have been refilled.
- out_ready=0: no push, no consume, counters freeze. A prev_valid pixel stays held upstream.
- Back-to-back frames: the next frame starts in the cycle after the final push with no bubble. A pad push at (0,0) is legal in the same cycle frame_done is set.
- Counter widths use clog2 of H_P and W_P, with a minimum of 1 bit.
- Elaboration-time parameter check: fail if Kh>H_P or Kw>W_P.

Decomposition:
- Shared package/header: clog2 function and padded-dimension localparams (H_P, W_P, OUT_H, OUT_W). The line buffer and PE array reuse them.
- One natural sub-module, raster_counter: parameterised 2-D (row, col) counter with an advance enable and wrap/last flags. It is reusable for the downstream output-map addressing.

Test Plan:
- Defaults, prev_valid=1 and out_ready=1 held:
  - 49 pushes in 49 consecutive cycles: 24 with zero=1 and 25 with prev_ready=1.
  - First window_valid appears in the cycle after push #17 (r=2,c=2) with window_row=0 and window_col=0.
  - 25 window_valid pulses in total, the last at (4,4).
  - frame_done pulses once, in the cycle after push #49.
- prev_valid=0 throughout: exactly 8 pad pushes (row 0 plus (1,0)), then the block stalls at (1,1) with prev_ready=1 and line_buffer_valid=0 indefinitely.
- Toggle out_ready 1/0 every cycle with prev_valid=1: a full frame takes 98 cycles. prev_ready and line_buffer_valid are never 1 while out_ready=0. The window sequence is identical to scenario 1.
- Assert rst=0 for one cycle after 30 pushes:
  - All outputs are 0 during reset.
  - The next push is at (0,0) with zero=1.
  - The first window_valid comes after 17 further pushes.
- Two frames back-to-back: the second frame's first push immediately follows the frame_done cycle, giving 50 windows total and 2 frame_done pulses.
- Kh=Kw=1, pad_h=pad_w=0, h=w=4: zero is never asserted, 16 pushes each consume, window_valid follows every push by 1 cycle, and indices run (0,0)..(3,3).

Source files
------------

// File: rtl/line_buffer_ctrl_pkg.sv
// Shared sizing helpers for the line-buffer / PE datapath: a width function
// and the padded / output map dimensions at the default layer geometry.
package line_buffer_ctrl_pkg;

    // Bits needed to index n values, never less than one bit.
    function automatic int clog2_min1(input int n);
        int bits;
        int v;
        bits = 0;
        v = n - 1;
        while (v > 0) begin
            bits = bits + 1;
            v = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    // Size of one map dimension after zero padding on both sides.
    function automatic int padded_dim(input int n, input int pad);
        return n + 2 * pad;
    endfunction

    // Number of stride-1 window positions along one padded dimension.
    function automatic int out_dim(input int n, input int pad, input int k);
        return n + 2 * pad - k + 1;
    endfunction

    localparam int DEF_KH    = 3;
    localparam int DEF_KW    = 3;
    localparam int DEF_H     = 5;
    localparam int DEF_W     = 5;
    localparam int DEF_PAD_H = 1;
    localparam int DEF_PAD_W = 1;

    localparam int H_P   = padded_dim(DEF_H, DEF_PAD_H);
    localparam int W_P   = padded_dim(DEF_W, DEF_PAD_W);
    localparam int OUT_H = out_dim(DEF_H, DEF_PAD_H, DEF_KH);
    localparam int OUT_W = out_dim(DEF_W, DEF_PAD_W, DEF_KW);

endpackage

// File: rtl/line_buffer_ctrl_raster.sv
// Two-dimensional raster counter: col runs fastest, row steps when col wraps,
// both wrap to zero after the last position. Holds whenever advance is low.
module raster_counter
    import line_buffer_ctrl_pkg::*;
#(
    parameter  int ROWS = H_P,
    parameter  int COLS = W_P,
    localparam int RW   = clog2_min1(ROWS),
    localparam int CW   = clog2_min1(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          row_last,
    output logic          col_last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    // Flags for the final column of a row and the final row of the map.
    always_comb begin
        row_last = (row == ROW_MAX);
        col_last = (col == COL_MAX);
    end

    // Position register: step on advance, wrap col into row, wrap the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Push/zero sequencer for the line buffer array. Walks the padded input map
// in raster order, injecting zero pushes at pad positions and consuming one
// upstream pixel at each interior position, and flags complete windows.
//
// Handshake: an upstream pixel transfers in a cycle where prev_valid and
// prev_ready are both 1. prev_ready depends only on position, out_ready and
// reset, never on prev_valid. out_ready=0 freezes everything for that cycle.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter  int Kh      = DEF_KH,
    parameter  int Kw      = DEF_KW,
    parameter  int h       = DEF_H,
    parameter  int w       = DEF_W,
    parameter  int pad_h   = DEF_PAD_H,
    parameter  int pad_w   = DEF_PAD_W,
    localparam int FRAME_H = padded_dim(h, pad_h),
    localparam int FRAME_W = padded_dim(w, pad_w),
    localparam int WIN_H   = out_dim(h, pad_h, Kh),
    localparam int WIN_W   = out_dim(w, pad_w, Kw),
    localparam int RW      = clog2_min1(FRAME_H),
    localparam int CW      = clog2_min1(FRAME_W),
    localparam int OW_R    = clog2_min1(WIN_H),
    localparam int OW_C    = clog2_min1(WIN_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prev_valid,
    output logic            prev_ready,
    input  logic            out_ready,
    output logic            line_buffer_valid,
    output logic            line_buffer_zero,
    output logic            window_valid,
    output logic [OW_R-1:0] window_row,
    output logic [OW_C-1:0] window_col,
    output logic            frame_done
);

    // A kernel larger than the padded map can never produce a window.
    if (Kh > FRAME_H) begin : g_bad_kh
        $error("line_buffer_ctrl: Kh larger than padded height");
    end
    if (Kw > FRAME_W) begin : g_bad_kw
        $error("line_buffer_ctrl: Kw larger than padded width");
    end

    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          row_last;
    logic          col_last;
    logic          is_pad;
    logic          push;
    logic          win_hit;

    raster_counter #(
        .ROWS (FRAME_H),
        .COLS (FRAME_W)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .advance  (push),
        .row      (r),
        .col      (c),
        .row_last (row_last),
        .col_last (col_last)
    );

    // Position decode and push/consume strobes; all gated off during reset.
    always_comb begin
        is_pad = (int'(r) < pad_h) || (int'(r) >= pad_h + h) ||
                 (int'(c) < pad_w) || (int'(c) >= pad_w + w);
        push              = rst & out_ready & (is_pad | prev_valid);
        line_buffer_valid = push;
        line_buffer_zero  = push & is_pad;
        prev_ready        = rst & out_ready & ~is_pad;
        win_hit           = push && (int'(r) >= Kh - 1) && (int'(c) >= Kw - 1);
    end

    // Window flag and indices trail the completing push by one cycle, in step
    // with the line buffer write; indices hold between windows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            window_valid <= 1'b0;
            window_row   <= '0;
            window_col   <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= win_hit;
            frame_done   <= push & row_last & col_last;
            if (win_hit) begin
                window_row <= OW_R'(int'(r) - (Kh - 1));
                window_col <= OW_C'(int'(c) - (Kw - 1));
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl at the default 5x5 pad-1 3x3 geometry,
// plus a 4x4 unpadded 1x1-kernel instance.
module tb_line_buffer_ctrl;

    logic       clk;
    logic       rst;
    logic       prev_valid;
    logic       prev_ready;
    logic       out_ready;
    logic       lbv;
    logic       lbz;
    logic       wv;
    logic [2:0] wr;
    logic [2:0] wc;
    logic       fd;

    logic       prev_valid1;
    logic       prev_ready1;
    logic       out_ready1;
    logic       lbv1;
    logic       lbz1;
    logic       wv1;
    logic [1:0] wr1;
    logic [1:0] wc1;
    logic       fd1;

    int vectors;
    int miscompares;

    // Expected position and registered outputs for the default instance.
    int er, ec;
    int exp_wv, exp_wr, exp_wc, exp_fd;

    // Per-scenario observed tallies.
    int n_push, n_zero, n_cons, n_win, n_fd, n_fd_push;
    int first_win_push, last_wr, last_wc;

    line_buffer_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .prev_valid        (prev_valid),
        .prev_ready        (prev_ready),
        .out_ready         (out_ready),
        .line_buffer_valid (lbv),
        .line_buffer_zero  (lbz),
        .window_valid      (wv),
        .window_row        (wr),
        .window_col        (wc),
        .frame_done        (fd)
    );

    line_buffer_ctrl #(
        .Kh(1), .Kw(1), .h(4), .w(4), .pad_h(0), .pad_w(0)
    ) dut1 (
        .clk               (clk),
        .rst               (rst),
        .prev_valid        (prev_valid1),
        .prev_ready        (prev_ready1),
        .out_ready         (out_ready1),
        .line_buffer_valid (lbv1),
        .line_buffer_zero  (lbz1),
        .window_valid      (wv1),
        .window_row        (wr1),
        .window_col        (wc1),
        .frame_done        (fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_push = 0; n_zero = 0; n_cons = 0; n_win = 0; n_fd = 0; n_fd_push = 0;
        first_win_push = -1; last_wr = -1; last_wc = -1;
    endtask

    // Hold reset across one rising edge; called at posedge+1, returns at posedge+1.
    task automatic do_reset();
        rst = 1'b0; prev_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("rst_lbv", int'(lbv), 0);
        check("rst_lbz", int'(lbz), 0);
        check("rst_prdy", int'(prev_ready), 0);
        check("rst_lbv1", int'(lbv1), 0);
        @(posedge clk); #1;
        check("rst_wv", int'(wv), 0);
        check("rst_fd", int'(fd), 0);
        check("rst_wr", int'(wr), 0);
        check("rst_wc", int'(wc), 0);
        rst = 1'b1;
        er = 0; ec = 0; exp_wv = 0; exp_wr = 0; exp_wc = 0; exp_fd = 0;
    endtask

    // One clock of the default instance: drive, check all outputs, advance.
    task automatic run_cycle(input logic pv, input logic ordy);
        int pad, push;
        prev_valid = pv; out_ready = ordy;
        #1;
        pad  = (er < 1 || er >= 6 || ec < 1 || ec >= 6) ? 1 : 0;
        push = (ordy && (pad == 1 || pv)) ? 1 : 0;
        check("lbv", int'(lbv), push);
        check("lbz", int'(lbz), (push == 1 && pad == 1) ? 1 : 0);
        check("prdy", int'(prev_ready), (ordy && pad == 0) ? 1 : 0);
        check("wv", int'(wv), exp_wv);
        check("wr", int'(wr), exp_wr);
        check("wc", int'(wc), exp_wc);
        check("fd", int'(fd), exp_fd);
        if (wv) begin
            if (first_win_push < 0) first_win_push = n_push;
            n_win++; last_wr = int'(wr); last_wc = int'(wc);
        end
        if (fd) begin
            n_fd++;
            if (lbv) n_fd_push++;
        end
        if (lbv) n_push++;
        if (lbz) n_zero++;
        if (prev_ready && pv) n_cons++;
        exp_wv = (push == 1 && er >= 2 && ec >= 2) ? 1 : 0;
        if (exp_wv == 1) begin exp_wr = er - 2; exp_wc = ec - 2; end
        exp_fd = (push == 1 && er == 6 && ec == 6) ? 1 : 0;
        if (push == 1) begin
            if (ec == 6) begin
                ec = 0;
                er = (er == 6) ? 0 : er + 1;
            end else begin
                ec = ec + 1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        prev_valid1 = 1'b0; out_ready1 = 1'b0;
        clear_stats();
        do_reset();

        // Full frame, input always available.
        for (int i = 0; i < 49; i++) run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);
        check("s1_pushes", n_push, 49);
        check("s1_zeros", n_zero, 24);
        check("s1_consumes", n_cons, 25);
        check("s1_first_win_push", first_win_push, 17);
        check("s1_windows", n_win, 25);
        check("s1_last_wr", last_wr, 4);
        check("s1_last_wc", last_wc, 4);
        check("s1_frame_done", n_fd, 1);

        // Upstream starved: only pad pushes, then parked at (1,1).
        clear_stats();
        for (int i = 0; i < 14; i++) run_cycle(1'b0, 1'b1);
        check("s2_pushes", n_push, 8);
        prev_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("s2_park_prdy", int'(prev_ready), 1);
        check("s2_park_lbv", int'(lbv), 0);
        do_reset();

        // out_ready toggling every cycle.
        clear_stats();
        for (int i = 0; i < 98; i++) run_cycle(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
        check("s3_pushes", n_push, 49);
        check("s3_consumes", n_cons, 25);
        check("s3_windows", n_win, 25);
        check("s3_first_win_push", first_win_push, 17);
        check("s3_frame_done", n_fd, 1);

        // Reset after 30 pushes abandons the frame.
        for (int i = 0; i < 30; i++) run_cycle(1'b1, 1'b1);
        do_reset();
        clear_stats();
        prev_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("s4_restart_zero", int'(lbz), 1);
        for (int i = 0; i < 49; i++) run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);
        check("s4_first_win_push", first_win_push, 17);
        check("s4_windows", n_win, 25);

        // Two frames back to back.
        clear_stats();
        for (int i = 0; i < 98; i++) run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);
        check("s5_pushes", n_push, 98);
        check("s5_windows", n_win, 50);
        check("s5_frame_done", n_fd, 2);
        check("s5_fd_with_push", n_fd_push, 1);

        // 1x1 kernel, no padding, 4x4 map.
        prev_valid1 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            out_ready1 = (i < 16) ? 1'b1 : 1'b0;
            #1;
            check("k1_lbv", int'(lbv1), (i < 16) ? 1 : 0);
            check("k1_lbz", int'(lbz1), 0);
            check("k1_prdy", int'(prev_ready1), (i < 16) ? 1 : 0);
            check("k1_wv", int'(wv1), (i >= 1) ? 1 : 0);
            if (i >= 1) begin
                check("k1_wr", int'(wr1), (i - 1) / 4);
                check("k1_wc", int'(wc1), (i - 1) % 4);
            end
            check("k1_fd", int'(fd1), (i == 16) ? 1 : 0);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
